// File: rtl/imem_stream_checker.sv
// imem_stream_checker
//   Holds a small program of {instruction, expected writeback, check flag}
//   entries, streams the instructions into a core under test and compares the
//   core's register-writeback data against the expected values. The comparison
//   is delayed by LAT cycles to line up with the core's writeback.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; core held in reset, program may be loaded
//   RUN   | one program entry presented on instr per cycle
//   DRAIN | LAT cycles of NOP while the last writebacks arrive
//   DONE  | run finished; result on pass/err_count; reload/restart ok
//
// Ports
//   clock, reset                  clock, async active-high reset
//   load_en/idx/instr/expect/chk  program entry write (IDLE/DONE only)
//   prog_len, start               run length (sampled on start), run request
//   wb_data                       core writeback data
//   instr, core_reset             instruction and reset to the core
//   busy, done, pass              run status
//   err_count, first_err_idx      saturating mismatch count, first bad entry
module imem_stream_checker #(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 16,
  parameter int                ADDR_W = 4,
  parameter int                LAT    = 1,
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_idx,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_expect,
  input  logic              load_chk,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] instr,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_instr  [DEPTH];
  logic [DATA_W-1:0] mem_expect [DEPTH];
  logic [DEPTH-1:0]  mem_chk;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic [2:0]        drain_cnt;

  logic              idle_or_done;
  logic              start_ok;
  logic [ADDR_W:0]   len_eff;
  logic              last_idx;

  logic [DATA_W-1:0] run_instr;
  logic [DATA_W-1:0] run_exp;
  logic              run_chk;

  logic              cmp_chk;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_idx;
  logic              mismatch;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_ok     = start && idle_or_done;
  assign len_eff      = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_idx     = ({1'b0, idx} == (len - (ADDR_W+1)'(1)));

  // Program memory is deliberately not reset so a program survives a core
  // reset and can simply be rerun.
  always_ff @(posedge clock) begin
    if (load_en && idle_or_done && ({1'b0, load_idx} < DEPTH_L)) begin
      mem_instr[load_idx]  <= load_instr;
      mem_expect[load_idx] <= load_expect;
      mem_chk[load_idx]    <= load_chk;
    end
  end

  assign run_instr = mem_instr[idx];
  assign run_exp   = mem_expect[idx];
  assign run_chk   = mem_chk[idx] && (state == S_RUN);

  // Delay line aligning each presented entry with its writeback.
  if (LAT == 0) begin : g_nopipe
    assign cmp_chk = run_chk;
    assign cmp_exp = run_exp;
    assign cmp_idx = idx;
  end else begin : g_pipe
    logic [LAT-1:0]    pipe_chk;
    logic [DATA_W-1:0] pipe_exp [LAT];
    logic [ADDR_W-1:0] pipe_idx [LAT];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pipe_chk <= '0;
      end else begin
        pipe_chk[0] <= run_chk;
        for (int i = 1; i < LAT; i++) pipe_chk[i] <= pipe_chk[i-1];
      end
    end

    always_ff @(posedge clock) begin
      pipe_exp[0] <= run_exp;
      pipe_idx[0] <= idx;
      for (int i = 1; i < LAT; i++) begin
        pipe_exp[i] <= pipe_exp[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end

    assign cmp_chk = pipe_chk[LAT-1];
    assign cmp_exp = pipe_exp[LAT-1];
    assign cmp_idx = pipe_idx[LAT-1];
  end

  assign mismatch = cmp_chk && (wb_data != cmp_exp);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      len           <= '0;
      drain_cnt     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len           <= len_eff;
        idx           <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
      end else begin
        if (state == S_RUN) idx <= idx + ADDR_W'(1);
        if (mismatch) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (err_count == 8'd0)  first_err_idx <= cmp_idx;
        end
      end
      // Reloaded every RUN cycle, so it holds LAT-1 on entry to DRAIN.
      if (state == S_RUN)        drain_cnt <= DRAIN_INIT;
      else if (state == S_DRAIN) drain_cnt <= drain_cnt - 3'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    instr      = NOP;
    core_reset = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        core_reset = 1'b1;
        done       = (state == S_DONE);
        pass       = (state == S_DONE) && (err_count == 8'd0);
        if (start) state_nxt = (len_eff == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        instr = run_instr;
        if (last_idx) state_nxt = (LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 3'd0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
